// File: rtl/enemy_pkg.sv
// Shared types for the enemy fire path: coordinate/id widths and the
// scheduler state encoding.
package enemy_pkg;

    localparam int unsigned ENEMY_ID_W = 4;
    localparam int unsigned COORD_W    = 11;

    typedef logic [COORD_W-1:0]    coord_t;
    typedef logic [ENEMY_ID_W-1:0] enemy_id_t;

    typedef enum logic [1:0] {
        COOLDOWN,
        SELECT,
        REQUEST
    } fire_state_t;

    // raw is at most 2*n-1, so a single conditional subtract is a full modulo.
    function automatic enemy_id_t wrapIndex(input logic [ENEMY_ID_W:0] raw,
                                            input int unsigned         n);
        if (32'(raw) >= n)
            return enemy_id_t'(32'(raw) - n);
        else
            return enemy_id_t'(raw);
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) advancing one step per enable.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       en,
    output logic [7:0] value
);

    logic feedback;

    assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            value <= SEED;
        else if (en)
            value <= {value[6:0], feedback};
    end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Picks the next alive enemy round-robin after a jittered frame cooldown and
// presents one fire request to the bullet spawner until ack, death or timeout.
module enemy_fire_scheduler
    import enemy_pkg::*;
#(
    parameter int unsigned AMOUNT_OF_ENEMIES    = 2,
    parameter int unsigned ENEMY_WIDTH          = 20,
    parameter int unsigned ENEMY_HEIGHT         = 20,
    parameter logic [7:0]  FIRE_COOLDOWN_FRAMES = 8'd60,
    parameter logic [7:0]  JITTER_MASK          = 8'h1F,
    parameter int unsigned ACK_TIMEOUT_FRAMES   = 4,
    parameter logic [7:0]  LFSR_SEED            = 8'hA5
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              startOfFrame,
    input  logic                              pause,
    input  logic [AMOUNT_OF_ENEMIES-1:0]      aliveMask,
    input  logic [AMOUNT_OF_ENEMIES*11-1:0]   enemiesTLX,
    input  logic [AMOUNT_OF_ENEMIES*11-1:0]   enemiesTLY,
    input  logic                              fireAck,
    output logic                              fireReq,
    output logic [3:0]                        fireEnemyId,
    output logic [10:0]                       fireX,
    output logic [10:0]                       fireY
);

    localparam enemy_id_t LAST_ID   = enemy_id_t'(AMOUNT_OF_ENEMIES - 1);
    localparam coord_t    X_OFF     = coord_t'(ENEMY_WIDTH / 2);
    localparam coord_t    Y_OFF     = coord_t'(ENEMY_HEIGHT);
    localparam logic [7:0] TIMEOUT_LAST =
        8'((ACK_TIMEOUT_FRAMES == 0) ? 0 : ACK_TIMEOUT_FRAMES - 1);

    fire_state_t state, nextState;

    logic [8:0]  cnt;
    logic [8:0]  reloadValue;
    logic [7:0]  tcnt;
    logic [7:0]  lfsrValue;
    enemy_id_t   ptr;
    enemy_id_t   k;
    enemy_id_t   cand;
    logic        reqReg;

    logic        candAlive;
    logic        shooterAlive;
    coord_t      candX;
    coord_t      candY;

    logic        latchShot;
    logic        reload;
    logic        ptrToShooter;
    logic        clearK;
    logic        incK;
    logic        cntDec;
    logic        tcntInc;

    lfsr8 #(
        .SEED(LFSR_SEED)
    ) jitterLfsr (
        .clk   (clk),
        .resetN(resetN),
        .en    (startOfFrame & ~pause),
        .value (lfsrValue)
    );

    assign reloadValue = {1'b0, FIRE_COOLDOWN_FRAMES} + {1'b0, lfsrValue & JITTER_MASK};
    assign cand        = wrapIndex({1'b0, ptr} + 5'd1 + {1'b0, k}, AMOUNT_OF_ENEMIES);

    always_comb begin
        candAlive    = 1'b0;
        shooterAlive = 1'b0;
        candX        = '0;
        candY        = '0;
        for (int unsigned i = 0; i < AMOUNT_OF_ENEMIES; i++) begin
            if (32'(cand) == i) begin
                candAlive = aliveMask[i];
                candX     = enemiesTLX[COORD_W*i +: COORD_W];
                candY     = enemiesTLY[COORD_W*i +: COORD_W];
            end
            if (32'(fireEnemyId) == i)
                shooterAlive = aliveMask[i];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= COOLDOWN;
        else
            state <= nextState;
    end

    // Pause suppresses every strobe, so all state below simply holds.
    always_comb begin
        nextState    = state;
        latchShot    = 1'b0;
        reload       = 1'b0;
        ptrToShooter = 1'b0;
        clearK       = 1'b0;
        incK         = 1'b0;
        cntDec       = 1'b0;
        tcntInc      = 1'b0;
        if (!pause) begin
            case (state)
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cnt <= 9'd1) begin
                            nextState = SELECT;
                            clearK    = 1'b1;
                        end else begin
                            cntDec = 1'b1;
                        end
                    end
                end
                SELECT: begin
                    if (candAlive) begin
                        nextState = REQUEST;
                        latchShot = 1'b1;
                    end else if (k == LAST_ID) begin
                        nextState = COOLDOWN;
                        reload    = 1'b1;
                    end else begin
                        incK = 1'b1;
                    end
                end
                REQUEST: begin
                    // Ack outranks both a dying shooter and an expiring timeout.
                    if (fireAck) begin
                        nextState    = COOLDOWN;
                        reload       = 1'b1;
                        ptrToShooter = 1'b1;
                    end else if (!shooterAlive) begin
                        nextState = SELECT;
                        clearK    = 1'b1;
                    end else if (startOfFrame) begin
                        if (tcnt >= TIMEOUT_LAST) begin
                            nextState    = COOLDOWN;
                            reload       = 1'b1;
                            ptrToShooter = 1'b1;
                        end else begin
                            tcntInc = 1'b1;
                        end
                    end
                end
                default: nextState = COOLDOWN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt         <= {1'b0, FIRE_COOLDOWN_FRAMES};
            ptr         <= LAST_ID;
            k           <= '0;
            tcnt        <= '0;
            reqReg      <= 1'b0;
            fireEnemyId <= '0;
            fireX       <= '0;
            fireY       <= '0;
        end else begin
            if (reload)
                cnt <= reloadValue;
            else if (cntDec)
                cnt <= cnt - 9'd1;

            if (clearK)
                k <= '0;
            else if (incK)
                k <= k + enemy_id_t'(1);

            if (ptrToShooter)
                ptr <= fireEnemyId;

            if (latchShot) begin
                tcnt        <= '0;
                fireEnemyId <= cand;
                fireX       <= candX + X_OFF;
                fireY       <= candY + Y_OFF;
            end else if (tcntInc) begin
                tcnt <= tcnt + 8'd1;
            end

            reqReg <= (nextState == REQUEST);
        end
    end

    assign fireReq = reqReg & ~pause;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Randomized scoreboard bench for enemy_fire_scheduler: a frame-level model
// predicts request start/drop cycles and shot data; a monitor compares.
module tb_enemy_fire_scheduler;

    localparam int N       = 3;
    localparam int CW      = 11;
    localparam int COOL    = 3;
    localparam int JM      = 3;
    localparam int TIMEOUT = 4;
    localparam int SEED    = 'hA5;
    localparam int XOFF    = 10;
    localparam int YOFF    = 20;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic            startOfFrame = 1'b0;
    logic            pause = 1'b0;
    logic            fireAck = 1'b0;
    logic [N-1:0]    aliveMask = '1;
    logic [N*CW-1:0] enemiesTLX = '0;
    logic [N*CW-1:0] enemiesTLY = '0;
    logic            fireReq;
    logic [3:0]      fireEnemyId;
    logic [10:0]     fireX;
    logic [10:0]     fireY;

    enemy_fire_scheduler #(
        .AMOUNT_OF_ENEMIES   (N),
        .ENEMY_WIDTH         (20),
        .ENEMY_HEIGHT        (20),
        .FIRE_COOLDOWN_FRAMES(8'(COOL)),
        .JITTER_MASK         (8'(JM)),
        .ACK_TIMEOUT_FRAMES  (TIMEOUT),
        .LFSR_SEED           (8'(SEED))
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .pause       (pause),
        .aliveMask   (aliveMask),
        .enemiesTLX  (enemiesTLX),
        .enemiesTLY  (enemiesTLY),
        .fireAck     (fireAck),
        .fireReq     (fireReq),
        .fireEnemyId (fireEnemyId),
        .fireX       (fireX),
        .fireY       (fireY)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int id;
        int x;
        int y;
    } shot_t;

    shot_t startQ[$];
    int    endQ[$];
    int    checks = 0;
    int    passes = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int cycle = 0;
    int mLfsr, mFramesLeft, mScanLeft, mScanHit, mPtr, mShooter, mReqFrames;
    bit mScanning, mRequesting, mEvent;

    function automatic int lfsrNext(int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 'hFF;
    endfunction

    function automatic bit isAlive(logic [N-1:0] m, int idx);
        return ((int'(m) >> idx) & 1) == 1;
    endfunction

    function automatic int slotCoord(logic [N*CW-1:0] v, int s);
        return int'((v >> (CW * s)) & 'h7FF);
    endfunction

    function automatic int firstAlive(int ptr, logic [N-1:0] m);
        for (int off = 0; off < N; off++)
            if (isAlive(m, (ptr + 1 + off) % N)) return off;
        return -1;
    endfunction

    task automatic modelReset();
        mLfsr       = SEED;
        mFramesLeft = COOL;
        mPtr        = N - 1;
        mScanning   = 0;
        mRequesting = 0;
        mShooter    = 0;
    endtask

    task automatic startScan();
        mScanning = 1;
        mScanHit  = firstAlive(mPtr, aliveMask);
        mScanLeft = (mScanHit >= 0) ? mScanHit + 1 : N;
    endtask

    task automatic endReq();
        mRequesting = 0;
        mEvent      = 1;
        endQ.push_back(cycle);
    endtask

    initial modelReset();

    always @(posedge clk) begin
        int reloadVal;
        cycle++;
        mEvent = 0;
        if (!resetN) begin
            modelReset();
        end else if (!pause) begin
            reloadVal = COOL + (mLfsr & JM);
            if (mRequesting) begin
                if (fireAck) begin
                    endReq();
                    mPtr = mShooter;
                    mFramesLeft = reloadVal;
                end else if (!isAlive(aliveMask, mShooter)) begin
                    endReq();
                    startScan();
                end else if (startOfFrame) begin
                    mReqFrames++;
                    if (mReqFrames >= TIMEOUT) begin
                        endReq();
                        mPtr = mShooter;
                        mFramesLeft = reloadVal;
                    end
                end
            end else if (mScanning) begin
                mScanLeft--;
                if (mScanLeft == 0) begin
                    mScanning = 0;
                    if (mScanHit >= 0) begin
                        mShooter    = (mPtr + 1 + mScanHit) % N;
                        mRequesting = 1;
                        mReqFrames  = 0;
                        mEvent      = 1;
                        startQ.push_back('{cycle, mShooter,
                            (slotCoord(enemiesTLX, mShooter) + XOFF) % 2048,
                            (slotCoord(enemiesTLY, mShooter) + YOFF) % 2048});
                    end else begin
                        mFramesLeft = reloadVal;
                    end
                end
            end else if (startOfFrame) begin
                if (mFramesLeft <= 1) startScan();
                else mFramesLeft--;
            end
            if (startOfFrame) mLfsr = lfsrNext(mLfsr);
        end
    end

    // ---------------- monitor ----------------
    bit inReq = 0;

    always @(negedge clk) begin
        shot_t e;
        if (!resetN) begin
            inReq = 0;
        end else if (pause) begin
            check("pause_forces_req_low", int'(fireReq), 0);
        end else if (fireReq && !inReq) begin
            inReq = 1;
            if (startQ.size() == 0) begin
                check("req_unexpected_qsize", startQ.size(), 1);
            end else begin
                e = startQ.pop_front();
                check("req_cycle", cycle, e.cyc);
                check("req_id", int'(fireEnemyId), e.id);
                check("req_x", int'(fireX), e.x);
                check("req_y", int'(fireY), e.y);
            end
        end else if (!fireReq && inReq) begin
            inReq = 0;
            if (endQ.size() == 0) check("drop_unexpected_qsize", endQ.size(), 1);
            else check("drop_cycle", cycle, endQ.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    int sofGap = 0;

    task automatic setSlot(int s, int x, int y);
        logic [N*CW-1:0] m;
        m = (N*CW)'(11'h7FF) << (CW * s);
        enemiesTLX = (enemiesTLX & ~m) | ((N*CW)'(x & 'h7FF) << (CW * s));
        enemiesTLY = (enemiesTLY & ~m) | ((N*CW)'(y & 'h7FF) << (CW * s));
    endtask

    task automatic tick(int ackPct, int killPct, int maskPct, int posPct, int pausePct);
        @(posedge clk);
        #1;
        if (sofGap == 0) begin
            startOfFrame = 1'b1;
            sofGap = int'($urandom_range(3, 9));
        end else begin
            startOfFrame = 1'b0;
            sofGap--;
        end
        fireAck = int'($urandom_range(0, 99)) < ackPct;
        if (!mScanning) begin
            if (mRequesting && int'($urandom_range(0, 99)) < killPct)
                aliveMask = aliveMask & ~(N'(1) << mShooter);
            if (int'($urandom_range(0, 99)) < maskPct)
                aliveMask = N'($urandom);
            if (int'($urandom_range(0, 99)) < posPct)
                setSlot(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2047)),
                        int'($urandom_range(0, 2047)));
        end
        if (!mEvent && int'($urandom_range(0, 99)) < pausePct)
            pause = ~pause;
    endtask

    task automatic setMask(logic [N-1:0] m);
        for (int i = 0; i < 50 && mScanning; i++) tick(0, 0, 0, 0, 0);
        if (mScanning) check("setmask_scan_bound", int'(mScanning), 0);
        aliveMask = m;
    endtask

    initial begin
        bit found;
        int frames;
        setSlot(0, 100, 100);
        setSlot(1, 300, 40);
        setSlot(2, 500, 60);
        aliveMask = 3'b111;

        @(negedge clk);
        check("reset_fireReq", int'(fireReq), 0);
        check("reset_id", int'(fireEnemyId), 0);
        check("reset_x", int'(fireX), 0);
        check("reset_y", int'(fireY), 0);
        @(posedge clk);
        #1 resetN = 1'b1;

        repeat (300) tick(40, 0, 0, 0, 0);
        setMask(3'b101);
        repeat (300) tick(40, 0, 0, 0, 0);
        repeat (400) tick(0, 0, 0, 0, 0);
        setMask(3'b111);
        repeat (400) tick(2, 10, 3, 0, 0);
        setMask(3'b000);
        repeat (200) tick(30, 0, 0, 0, 0);
        setMask(3'b010);
        repeat (150) tick(30, 0, 0, 0, 0);

        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick(40, 0, 0, 0, 0);
            found = !mScanning && !mRequesting && mFramesLeft == 2 && !mEvent;
        end
        check("pause_setup_bound", int'(found), 1);
        pause = 1'b1;
        frames = 0;
        for (int i = 0; i < 300 && frames < 10; i++) begin
            tick(40, 0, 0, 0, 0);
            if (startOfFrame) frames++;
        end
        check("pause_frames_bound", frames, 10);
        pause = 1'b0;
        repeat (300) tick(40, 0, 0, 0, 0);

        repeat (1500) tick(15, 3, 4, 5, 2);
        pause = 1'b0;
        setMask(3'b111);

        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick(0, 0, 0, 0, 0);
            found = mRequesting && !mEvent;
        end
        check("reset_wait_bound", int'(found), 1);
        check("req_before_async_reset", int'(fireReq), 1);
        #2 resetN = 1'b0;
        #1 check("async_reset_drops_req", int'(fireReq), 0);
        @(posedge clk);
        @(posedge clk);
        #1 resetN = 1'b1;
        repeat (400) tick(25, 2, 3, 5, 1);

        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick(0, 0, 0, 0, 0);
            found = !mEvent;
        end
        pause = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pending_requests", startQ.size(), 0);
        check("pending_drops", endQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
